// File: rtl/checkpoint_restore_ctrl_pkg.sv
// Shared types for the branch checkpoint restore controller: ROB / column /
// register tag widths, tracking-table entry layout and controller FSM states.
package checkpoint_restore_ctrl_pkg;

    localparam int ROB_ENTRIES        = 64;
    localparam int CHECKPOINT_COLUMNS = 4;
    localparam int ARCH_REGS          = 32;
    localparam int PHYS_REGS          = 64;

    // One map-table column is always the working column, so one fewer can
    // hold a branch checkpoint.
    localparam int CKPT_ENTRIES = CHECKPOINT_COLUMNS - 1;
    localparam int CKPT_IDX_W   = (CKPT_ENTRIES > 1) ? $clog2(CKPT_ENTRIES) : 1;
    localparam int CKPT_CNT_W   = $clog2(CKPT_ENTRIES + 1);

    typedef logic [$clog2(ROB_ENTRIES)-1:0]        ROB_index_t;
    typedef logic [$clog2(CHECKPOINT_COLUMNS)-1:0] checkpoint_column_t;
    typedef logic [$clog2(ARCH_REGS)-1:0]          arch_reg_tag_t;
    typedef logic [$clog2(PHYS_REGS)-1:0]          phys_reg_tag_t;
    typedef logic [CKPT_IDX_W-1:0]                 ckpt_idx_t;
    typedef logic [CKPT_CNT_W-1:0]                 ckpt_count_t;

    localparam ckpt_count_t CKPT_FULL = ckpt_count_t'(CKPT_ENTRIES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RESTORE,
        ST_REVERT_START,
        ST_REVERT_WALK
    } ckpt_ctrl_state_t;

    typedef struct packed {
        logic               valid;
        ROB_index_t         ROB_index;
        checkpoint_column_t column;
    } ckpt_entry_t;

endpackage

// File: rtl/checkpoint_restore_ctrl_if.sv
// Bus between the checkpoint controller and its neighbours: dispatch, branch
// resolution, the physical register map table and the ROB revert walker.
// slave = the controller, master = the surrounding pipeline.
interface checkpoint_restore_ctrl_if;
    import checkpoint_restore_ctrl_pkg::*;

    logic               dispatch_save_valid;
    ROB_index_t         dispatch_save_ROB_index;
    logic               save_ready;
    logic               save_checkpoint_valid;
    ROB_index_t         save_checkpoint_ROB_index;
    checkpoint_column_t save_checkpoint_safe_column;

    logic               resolve_valid;
    ROB_index_t         resolve_ROB_index;
    logic               resolve_mispredict;
    logic               resolve_ready;

    logic               restore_checkpoint_valid;
    logic               restore_checkpoint_speculate_failed;
    ROB_index_t         restore_checkpoint_ROB_index;
    checkpoint_column_t restore_checkpoint_safe_column;
    logic               restore_checkpoint_success;

    logic               rob_revert_start;
    ROB_index_t         rob_revert_target_ROB_index;
    logic               rob_revert_valid;
    arch_reg_tag_t      rob_revert_arch_reg_tag;
    phys_reg_tag_t      rob_revert_safe_phys_reg_tag;
    phys_reg_tag_t      rob_revert_speculated_phys_reg_tag;
    logic               rob_revert_done;

    logic               revert_valid;
    arch_reg_tag_t      revert_dest_arch_reg_tag;
    phys_reg_tag_t      revert_safe_dest_phys_reg_tag;
    phys_reg_tag_t      revert_speculated_dest_phys_reg_tag;

    logic               mispredict_done;
    logic               flush_full_req;

    modport slave (
        input  dispatch_save_valid, dispatch_save_ROB_index, save_checkpoint_safe_column,
        input  resolve_valid, resolve_ROB_index, resolve_mispredict,
        input  restore_checkpoint_success,
        input  rob_revert_valid, rob_revert_arch_reg_tag, rob_revert_safe_phys_reg_tag,
        input  rob_revert_speculated_phys_reg_tag, rob_revert_done,
        output save_ready, save_checkpoint_valid, save_checkpoint_ROB_index,
        output resolve_ready,
        output restore_checkpoint_valid, restore_checkpoint_speculate_failed,
        output restore_checkpoint_ROB_index, restore_checkpoint_safe_column,
        output rob_revert_start, rob_revert_target_ROB_index,
        output revert_valid, revert_dest_arch_reg_tag, revert_safe_dest_phys_reg_tag,
        output revert_speculated_dest_phys_reg_tag,
        output mispredict_done, flush_full_req
    );

    modport master (
        output dispatch_save_valid, dispatch_save_ROB_index, save_checkpoint_safe_column,
        output resolve_valid, resolve_ROB_index, resolve_mispredict,
        output restore_checkpoint_success,
        output rob_revert_valid, rob_revert_arch_reg_tag, rob_revert_safe_phys_reg_tag,
        output rob_revert_speculated_phys_reg_tag, rob_revert_done,
        input  save_ready, save_checkpoint_valid, save_checkpoint_ROB_index,
        input  resolve_ready,
        input  restore_checkpoint_valid, restore_checkpoint_speculate_failed,
        input  restore_checkpoint_ROB_index, restore_checkpoint_safe_column,
        input  rob_revert_start, rob_revert_target_ROB_index,
        input  revert_valid, revert_dest_arch_reg_tag, revert_safe_dest_phys_reg_tag,
        input  revert_speculated_dest_phys_reg_tag,
        input  mispredict_done, flush_full_req
    );

endinterface

// File: rtl/checkpoint_restore_ctrl_tag_cam.sv
// checkpoint_tag_cam: small fully associative table mapping branch ROB index
// to its saved map-table column. Lowest-free allocation, lowest-match lookup
// against the pre-cycle contents, single-entry and whole-table clear.
module checkpoint_tag_cam
    import checkpoint_restore_ctrl_pkg::*;
(
    input  logic               CLK,
    input  logic               nRST,
    input  logic               alloc_valid,
    input  ROB_index_t         alloc_ROB_index,
    input  checkpoint_column_t alloc_column,
    input  ROB_index_t         lookup_ROB_index,
    output logic               lookup_hit,
    output ckpt_idx_t          lookup_idx,
    output checkpoint_column_t lookup_column,
    input  logic               clear_one_valid,
    input  ckpt_idx_t          clear_one_idx,
    input  logic               clear_all
);

    ckpt_entry_t table_q [CKPT_ENTRIES];
    logic        free_found;
    ckpt_idx_t   free_idx;

    // Pick the lowest-index free entry; scanning downward lets the lowest win.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path can hold a stale value and infer a latch.
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = CKPT_ENTRIES - 1; i >= 0; i--) begin
            if (!table_q[i].valid) begin
                free_found = 1'b1;
                free_idx   = ckpt_idx_t'(i);
            end
        end
    end

    // Match the resolving ROB index against valid entries (lowest match wins).
    always_comb begin
        lookup_hit    = 1'b0;
        lookup_idx    = '0;
        lookup_column = '0;
        for (int i = CKPT_ENTRIES - 1; i >= 0; i--) begin
            if (table_q[i].valid && (table_q[i].ROB_index == lookup_ROB_index)) begin
                lookup_hit    = 1'b1;
                lookup_idx    = ckpt_idx_t'(i);
                lookup_column = table_q[i].column;
            end
        end
    end

    // Table update: clears first, allocation last so a same-cycle save survives a flush.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            // NOTE: the table is a handful of flops whose valid bits must start clear, so it is reset; large RAM-style storage would not be.
            for (int i = 0; i < CKPT_ENTRIES; i++) begin
                table_q[i] <= '0;
            end
        end else begin
            // NOTE: state uses non-blocking assignment so later statements in this block still see the pre-edge table.
            for (int i = 0; i < CKPT_ENTRIES; i++) begin
                if (clear_all) begin
                    table_q[i].valid <= 1'b0;
                end
            end
            if (clear_one_valid) begin
                table_q[clear_one_idx].valid <= 1'b0;
            end
            if (alloc_valid && free_found) begin
                table_q[free_idx] <= '{valid: 1'b1, ROB_index: alloc_ROB_index, column: alloc_column};
            end
        end
    end

endmodule

// File: rtl/checkpoint_restore_ctrl.sv
// checkpoint_restore_ctrl: forwards branch checkpoint saves to the map table,
// tracks branch ROB index -> safe column, and on resolution issues a restore
// or invalidate. A mispredict with no usable checkpoint falls back to either a
// ROB-driven revert walk (CKPT_REVERT_FALLBACK_EN defined) or a one-cycle
// flush_full_req pulse (macro undefined, the default build).
module checkpoint_restore_ctrl
    import checkpoint_restore_ctrl_pkg::*;
(
    input  logic                    CLK,
    input  logic                    nRST,
    checkpoint_restore_ctrl_if.slave bus
);

    ckpt_ctrl_state_t   state_q, state_d;
    ckpt_count_t        count_q;
    logic               flush_q, flush_set;
    logic               save_accept, resolve_accept;
    logic               lookup_hit;
    ckpt_idx_t          lookup_idx;
    checkpoint_column_t lookup_column;
    logic               clear_one, clear_all;
    ckpt_idx_t          res_idx;
    checkpoint_column_t res_column;
    ROB_index_t         res_ROB_index;
    logic               res_mispredict;

    assign bus.save_ready                = (state_q == ST_IDLE) && (count_q < CKPT_FULL);
    assign bus.resolve_ready             = (state_q == ST_IDLE);
    assign save_accept                   = bus.dispatch_save_valid && bus.save_ready;
    assign resolve_accept                = bus.resolve_valid && bus.resolve_ready;
    assign bus.save_checkpoint_valid     = save_accept;
    assign bus.save_checkpoint_ROB_index = save_accept ? bus.dispatch_save_ROB_index : '0;

`ifdef CKPT_REVERT_FALLBACK_EN
    assign bus.flush_full_req = 1'b0;
`else
    assign bus.flush_full_req = flush_q;
    // Walk inputs have no consumer when the flush fallback is built.
    logic unused_revert_inputs;
    assign unused_revert_inputs = ^{bus.rob_revert_valid, bus.rob_revert_arch_reg_tag,
                                    bus.rob_revert_safe_phys_reg_tag,
                                    bus.rob_revert_speculated_phys_reg_tag, bus.rob_revert_done};
`endif

    checkpoint_tag_cam u_cam (
        .CLK             (CLK),
        .nRST            (nRST),
        .alloc_valid     (save_accept),
        .alloc_ROB_index (bus.dispatch_save_ROB_index),
        .alloc_column    (bus.save_checkpoint_safe_column),
        .lookup_ROB_index(bus.resolve_ROB_index),
        .lookup_hit      (lookup_hit),
        .lookup_idx      (lookup_idx),
        .lookup_column   (lookup_column),
        .clear_one_valid (clear_one),
        .clear_one_idx   (res_idx),
        .clear_all       (clear_all)
    );

    // FSM state, occupancy count and pending-flush flag.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            flush_q <= flush_set;
            if (clear_all) begin
                count_q <= save_accept ? ckpt_count_t'(1) : '0;
            end else if (save_accept && !clear_one) begin
                count_q <= count_q + ckpt_count_t'(1);
            end else if (!save_accept && clear_one) begin
                count_q <= count_q - ckpt_count_t'(1);
            end
        end
    end

    // Capture the accepted resolution and its lookup result against the pre-cycle table.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            res_idx        <= '0;
            res_column     <= '0;
            res_ROB_index  <= '0;
            res_mispredict <= 1'b0;
        end else if (resolve_accept) begin
            res_idx        <= lookup_idx;
            res_column     <= lookup_column;
            res_ROB_index  <= bus.resolve_ROB_index;
            res_mispredict <= bus.resolve_mispredict;
        end
    end

    // Next state, table clears and map-table / ROB walk outputs.
    always_comb begin
        state_d                                 = state_q;
        flush_set                               = 1'b0;
        clear_one                               = 1'b0;
        clear_all                               = flush_q;
        bus.mispredict_done                     = 1'b0;
        bus.restore_checkpoint_valid            = 1'b0;
        bus.restore_checkpoint_speculate_failed = 1'b0;
        bus.restore_checkpoint_ROB_index        = '0;
        bus.restore_checkpoint_safe_column      = '0;
        bus.rob_revert_start                    = 1'b0;
        bus.rob_revert_target_ROB_index         = '0;
        bus.revert_valid                        = 1'b0;
        bus.revert_dest_arch_reg_tag            = '0;
        bus.revert_safe_dest_phys_reg_tag       = '0;
        bus.revert_speculated_dest_phys_reg_tag = '0;

        case (state_q)
            ST_IDLE: begin
                if (resolve_accept) begin
                    if (lookup_hit) begin
                        state_d = ST_RESTORE;
                    end else if (bus.resolve_mispredict) begin
`ifdef CKPT_REVERT_FALLBACK_EN
                        state_d = ST_REVERT_START;
`else
                        flush_set = 1'b1;
`endif
                    end
                end
            end

            ST_RESTORE: begin
                bus.restore_checkpoint_valid            = 1'b1;
                bus.restore_checkpoint_speculate_failed = res_mispredict;
                bus.restore_checkpoint_ROB_index        = res_ROB_index;
                bus.restore_checkpoint_safe_column      = res_column;
                state_d                                 = ST_IDLE;
                if (!res_mispredict) begin
                    clear_one = 1'b1;
                end else if (bus.restore_checkpoint_success) begin
                    clear_all           = 1'b1;
                    bus.mispredict_done = 1'b1;
                end else begin
`ifdef CKPT_REVERT_FALLBACK_EN
                    state_d = ST_REVERT_START;
`else
                    flush_set = 1'b1;
`endif
                end
            end

`ifdef CKPT_REVERT_FALLBACK_EN
            ST_REVERT_START: begin
                bus.rob_revert_start            = 1'b1;
                bus.rob_revert_target_ROB_index = res_ROB_index;
                state_d                         = ST_REVERT_WALK;
            end

            ST_REVERT_WALK: begin
                bus.revert_valid                        = bus.rob_revert_valid;
                bus.revert_dest_arch_reg_tag            = bus.rob_revert_arch_reg_tag;
                bus.revert_safe_dest_phys_reg_tag       = bus.rob_revert_safe_phys_reg_tag;
                bus.revert_speculated_dest_phys_reg_tag = bus.rob_revert_speculated_phys_reg_tag;
                if (bus.rob_revert_done) begin
                    clear_all           = 1'b1;
                    bus.mispredict_done = 1'b1;
                    state_d             = ST_IDLE;
                end
            end
`else
            ST_REVERT_START: state_d = ST_IDLE;
            ST_REVERT_WALK:  state_d = ST_IDLE;
`endif

            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_checkpoint_restore_ctrl.sv
// Directed bench for checkpoint_restore_ctrl. Inputs change on the falling
// edge; outputs are sampled 1ns later, well away from the rising edge.
// Builds with or without CKPT_REVERT_FALLBACK_EN.
module tb_checkpoint_restore_ctrl;
    import checkpoint_restore_ctrl_pkg::*;

    logic CLK = 1'b0;
    logic nRST;
    int   checks = 0;
    int   errors = 0;

    checkpoint_restore_ctrl_if bus();

    checkpoint_restore_ctrl dut (
        .CLK (CLK),
        .nRST(nRST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        bus.dispatch_save_valid                = 1'b0;
        bus.dispatch_save_ROB_index            = '0;
        bus.save_checkpoint_safe_column        = '0;
        bus.resolve_valid                      = 1'b0;
        bus.resolve_ROB_index                  = '0;
        bus.resolve_mispredict                 = 1'b0;
        bus.rob_revert_valid                   = 1'b0;
        bus.rob_revert_arch_reg_tag            = '0;
        bus.rob_revert_safe_phys_reg_tag       = '0;
        bus.rob_revert_speculated_phys_reg_tag = '0;
        bus.rob_revert_done                    = 1'b0;
    endtask

    task automatic step();
        @(negedge CLK);
        idle_inputs();
        #1;
    endtask

    task automatic save_step(input ROB_index_t rob, input checkpoint_column_t col);
        @(negedge CLK);
        idle_inputs();
        bus.dispatch_save_valid         = 1'b1;
        bus.dispatch_save_ROB_index     = rob;
        bus.save_checkpoint_safe_column = col;
        #1;
    endtask

    task automatic resolve_step(input ROB_index_t rob, input logic misp);
        @(negedge CLK);
        idle_inputs();
        bus.resolve_valid      = 1'b1;
        bus.resolve_ROB_index  = rob;
        bus.resolve_mispredict = misp;
        #1;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        idle_inputs();
        bus.restore_checkpoint_success = 1'b0;
        repeat (2) @(negedge CLK);
        nRST = 1'b1;
        step();
        checks++; if (bus.save_ready !== 1'b1) begin errors++; $display("FAIL reset_save_ready: got %0b expected 1", bus.save_ready); end
        checks++; if (bus.resolve_ready !== 1'b1) begin errors++; $display("FAIL reset_resolve_ready: got %0b expected 1", bus.resolve_ready); end
        checks++; if (bus.restore_checkpoint_valid !== 1'b0) begin errors++; $display("FAIL reset_restore_valid: got %0b expected 0", bus.restore_checkpoint_valid); end
        checks++; if (bus.save_checkpoint_valid !== 1'b0) begin errors++; $display("FAIL reset_save_valid: got %0b expected 0", bus.save_checkpoint_valid); end
        checks++; if ({bus.mispredict_done, bus.flush_full_req, bus.rob_revert_start, bus.revert_valid} !== 4'b0000) begin
            errors++; $display("FAIL reset_pulses: got %4b expected 0000", {bus.mispredict_done, bus.flush_full_req, bus.rob_revert_start, bus.revert_valid}); end
    endtask

    task automatic test_save_restore_correct();
        save_step(6'd5, 2'd0);
        checks++; if (bus.save_checkpoint_valid !== 1'b1) begin errors++; $display("FAIL save5_valid: got %0b expected 1", bus.save_checkpoint_valid); end
        checks++; if (bus.save_checkpoint_ROB_index !== 6'd5) begin errors++; $display("FAIL save5_rob: got %0d expected 5", bus.save_checkpoint_ROB_index); end
        resolve_step(6'd5, 1'b0);
        checks++; if (bus.restore_checkpoint_valid !== 1'b0) begin errors++; $display("FAIL res5_restore_at_n: got %0b expected 0", bus.restore_checkpoint_valid); end
        step();
        checks++; if (bus.restore_checkpoint_valid !== 1'b1) begin errors++; $display("FAIL res5_restore_valid: got %0b expected 1", bus.restore_checkpoint_valid); end
        checks++; if (bus.restore_checkpoint_speculate_failed !== 1'b0) begin errors++; $display("FAIL res5_spec_failed: got %0b expected 0", bus.restore_checkpoint_speculate_failed); end
        checks++; if (bus.restore_checkpoint_ROB_index !== 6'd5) begin errors++; $display("FAIL res5_rob: got %0d expected 5", bus.restore_checkpoint_ROB_index); end
        checks++; if (bus.restore_checkpoint_safe_column !== 2'd0) begin errors++; $display("FAIL res5_column: got %0d expected 0", bus.restore_checkpoint_safe_column); end
        checks++; if (bus.mispredict_done !== 1'b0) begin errors++; $display("FAIL res5_done: got %0b expected 0", bus.mispredict_done); end
        checks++; if (bus.save_ready !== 1'b0) begin errors++; $display("FAIL res5_save_ready_in_restore: got %0b expected 0", bus.save_ready); end
        step();
        checks++; if (bus.restore_checkpoint_valid !== 1'b0) begin errors++; $display("FAIL res5_restore_one_cycle: got %0b expected 0", bus.restore_checkpoint_valid); end
        checks++; if (dut.count_q !== 2'd0) begin errors++; $display("FAIL res5_count: got %0d expected 0", dut.count_q); end
    endtask

    task automatic test_mispredict_success();
        bus.restore_checkpoint_success = 1'b1;
        save_step(6'd3, 2'd1);
        resolve_step(6'd3, 1'b1);
        step();
        checks++; if (bus.restore_checkpoint_valid !== 1'b1) begin errors++; $display("FAIL mis3_restore_valid: got %0b expected 1", bus.restore_checkpoint_valid); end
        checks++; if (bus.restore_checkpoint_speculate_failed !== 1'b1) begin errors++; $display("FAIL mis3_spec_failed: got %0b expected 1", bus.restore_checkpoint_speculate_failed); end
        checks++; if (bus.restore_checkpoint_safe_column !== 2'd1) begin errors++; $display("FAIL mis3_column: got %0d expected 1", bus.restore_checkpoint_safe_column); end
        checks++; if (bus.mispredict_done !== 1'b1) begin errors++; $display("FAIL mis3_done: got %0b expected 1", bus.mispredict_done); end
        step();
        bus.restore_checkpoint_success = 1'b0;
        checks++; if (bus.mispredict_done !== 1'b0) begin errors++; $display("FAIL mis3_done_pulse: got %0b expected 0", bus.mispredict_done); end
        checks++; if (dut.count_q !== 2'd0) begin errors++; $display("FAIL mis3_count: got %0d expected 0", dut.count_q); end
        // Table must be empty: a correct resolve of ROB 3 now misses and does nothing.
        resolve_step(6'd3, 1'b0);
        step();
        checks++; if (bus.restore_checkpoint_valid !== 1'b0) begin errors++; $display("FAIL mis3_table_cleared: got %0b expected 0", bus.restore_checkpoint_valid); end
    endtask

    task automatic test_fill();
        save_step(6'd10, 2'd1);
        save_step(6'd11, 2'd2);
        save_step(6'd12, 2'd3);
        checks++; if (bus.save_checkpoint_valid !== 1'b1) begin errors++; $display("FAIL fill_third_save: got %0b expected 1", bus.save_checkpoint_valid); end
        save_step(6'd13, 2'd0);
        checks++; if (bus.save_ready !== 1'b0) begin errors++; $display("FAIL fill_save_ready: got %0b expected 0", bus.save_ready); end
        checks++; if (bus.save_checkpoint_valid !== 1'b0) begin errors++; $display("FAIL fill_save_blocked: got %0b expected 0", bus.save_checkpoint_valid); end
        resolve_step(6'd11, 1'b0);
        step();
        checks++; if (bus.restore_checkpoint_ROB_index !== 6'd11) begin errors++; $display("FAIL fill_res11_rob: got %0d expected 11", bus.restore_checkpoint_ROB_index); end
        checks++; if (bus.restore_checkpoint_safe_column !== 2'd2) begin errors++; $display("FAIL fill_res11_column: got %0d expected 2", bus.restore_checkpoint_safe_column); end
        step();
        checks++; if (bus.save_ready !== 1'b1) begin errors++; $display("FAIL fill_save_ready_after: got %0b expected 1", bus.save_ready); end
    endtask

    task automatic test_back_to_back();
        // Save ROB 20 into the slot freed by ROB 11 while ROB 10 resolves.
        save_step(6'd20, 2'd0);
        bus.resolve_valid     = 1'b1;
        bus.resolve_ROB_index = 6'd10;
        #1;
        checks++; if ({bus.save_checkpoint_valid, bus.resolve_ready} !== 2'b11) begin errors++; $display("FAIL b2b_accept: got %2b expected 11", {bus.save_checkpoint_valid, bus.resolve_ready}); end
        step();
        checks++; if (bus.restore_checkpoint_safe_column !== 2'd1) begin errors++; $display("FAIL b2b_res10_column: got %0d expected 1", bus.restore_checkpoint_safe_column); end
        checks++; if (dut.count_q !== 2'd3) begin errors++; $display("FAIL b2b_count_peak: got %0d expected 3", dut.count_q); end
        resolve_step(6'd20, 1'b0);
        checks++; if (dut.count_q !== 2'd2) begin errors++; $display("FAIL b2b_count_after: got %0d expected 2", dut.count_q); end
        step();
        checks++; if ({bus.restore_checkpoint_valid, bus.restore_checkpoint_ROB_index} !== {1'b1, 6'd20}) begin
            errors++; $display("FAIL b2b_res20_rob: got %0d expected 20", bus.restore_checkpoint_ROB_index); end
        resolve_step(6'd12, 1'b0);
        step();
        checks++; if (bus.restore_checkpoint_safe_column !== 2'd3) begin errors++; $display("FAIL b2b_res12_column: got %0d expected 3", bus.restore_checkpoint_safe_column); end
        step();
        checks++; if (dut.count_q !== 2'd0) begin errors++; $display("FAIL b2b_count_empty: got %0d expected 0", dut.count_q); end
    endtask

`ifdef CKPT_REVERT_FALLBACK_EN
    task automatic test_revert_walk();
        arch_reg_tag_t arch_v [3] = '{5'd4, 5'd17, 5'd31};
        phys_reg_tag_t safe_v [3] = '{6'd10, 6'd33, 6'd2};
        phys_reg_tag_t spec_v [3] = '{6'd40, 6'd41, 6'd63};
        resolve_step(6'd9, 1'b1);
        step();
        checks++; if (bus.rob_revert_start !== 1'b1) begin errors++; $display("FAIL walk_start: got %0b expected 1", bus.rob_revert_start); end
        checks++; if (bus.rob_revert_target_ROB_index !== 6'd9) begin errors++; $display("FAIL walk_target: got %0d expected 9", bus.rob_revert_target_ROB_index); end
        checks++; if (bus.flush_full_req !== 1'b0) begin errors++; $display("FAIL walk_no_flush: got %0b expected 0", bus.flush_full_req); end
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            idle_inputs();
            bus.rob_revert_valid                   = 1'b1;
            bus.rob_revert_arch_reg_tag            = arch_v[i];
            bus.rob_revert_safe_phys_reg_tag       = safe_v[i];
            bus.rob_revert_speculated_phys_reg_tag = spec_v[i];
            #1;
            checks++; if ({bus.revert_valid, bus.revert_dest_arch_reg_tag, bus.revert_safe_dest_phys_reg_tag, bus.revert_speculated_dest_phys_reg_tag} !== {1'b1, arch_v[i], safe_v[i], spec_v[i]}) begin
                errors++; $display("FAIL walk_entry%0d: got %0d/%0d/%0d expected %0d/%0d/%0d", i, bus.revert_dest_arch_reg_tag, bus.revert_safe_dest_phys_reg_tag, bus.revert_speculated_dest_phys_reg_tag, arch_v[i], safe_v[i], spec_v[i]); end
            checks++; if ({bus.restore_checkpoint_valid, bus.rob_revert_start} !== 2'b00) begin errors++; $display("FAIL walk_exclusive%0d: got %2b expected 00", i, {bus.restore_checkpoint_valid, bus.rob_revert_start}); end
        end
        @(negedge CLK);
        idle_inputs();
        bus.rob_revert_done = 1'b1;
        #1;
        checks++; if (bus.mispredict_done !== 1'b1) begin errors++; $display("FAIL walk_done: got %0b expected 1", bus.mispredict_done); end
        step();
        checks++; if ({bus.mispredict_done, bus.resolve_ready} !== 2'b01) begin errors++; $display("FAIL walk_idle_after: got %2b expected 01", {bus.mispredict_done, bus.resolve_ready}); end
        // Failed restore also falls back to the walk, one cycle later.
        save_step(6'd7, 2'd2);
        resolve_step(6'd7, 1'b1);
        step();
        checks++; if ({bus.restore_checkpoint_valid, bus.mispredict_done} !== 2'b10) begin errors++; $display("FAIL walk_fail_restore: got %2b expected 10", {bus.restore_checkpoint_valid, bus.mispredict_done}); end
        step();
        checks++; if ({bus.rob_revert_start, bus.rob_revert_target_ROB_index} !== {1'b1, 6'd7}) begin errors++; $display("FAIL walk_fail_target: got %0d expected 7", bus.rob_revert_target_ROB_index); end
        @(negedge CLK);
        idle_inputs();
        bus.rob_revert_done = 1'b1;
        #1;
        checks++; if (bus.mispredict_done !== 1'b1) begin errors++; $display("FAIL walk_fail_done: got %0b expected 1", bus.mispredict_done); end
        step();
        checks++; if (dut.count_q !== 2'd0) begin errors++; $display("FAIL walk_fail_count: got %0d expected 0", dut.count_q); end
    endtask

    task automatic test_reset_mid();
        resolve_step(6'd9, 1'b1);
        step();
        @(negedge CLK);
        idle_inputs();
        bus.rob_revert_valid = 1'b1;
        bus.rob_revert_done  = 1'b1;
        #1;
        nRST = 1'b0;
        #1;
        checks++; if ({bus.revert_valid, bus.mispredict_done} !== 2'b00) begin errors++; $display("FAIL rstmid_outputs: got %2b expected 00", {bus.revert_valid, bus.mispredict_done}); end
        checks++; if ({bus.save_ready, bus.resolve_ready} !== 2'b11) begin errors++; $display("FAIL rstmid_ready: got %2b expected 11", {bus.save_ready, bus.resolve_ready}); end
        @(negedge CLK);
        nRST = 1'b1;
        save_step(6'd2, 2'd1);
        checks++; if ({bus.save_checkpoint_valid, bus.save_checkpoint_ROB_index} !== {1'b1, 6'd2}) begin errors++; $display("FAIL rstmid_save2: got %0b/%0d expected 1/2", bus.save_checkpoint_valid, bus.save_checkpoint_ROB_index); end
        step();
        checks++; if (dut.count_q !== 2'd1) begin errors++; $display("FAIL rstmid_count: got %0d expected 1", dut.count_q); end
    endtask
`else
    task automatic test_flush();
        resolve_step(6'd9, 1'b1);
        checks++; if (bus.flush_full_req !== 1'b0) begin errors++; $display("FAIL flush_not_at_n: got %0b expected 0", bus.flush_full_req); end
        step();
        checks++; if (bus.flush_full_req !== 1'b1) begin errors++; $display("FAIL flush_miss_pulse: got %0b expected 1", bus.flush_full_req); end
        checks++; if ({bus.rob_revert_start, bus.restore_checkpoint_valid, bus.mispredict_done, bus.revert_valid} !== 4'b0000) begin
            errors++; $display("FAIL flush_miss_quiet: got %4b expected 0000", {bus.rob_revert_start, bus.restore_checkpoint_valid, bus.mispredict_done, bus.revert_valid}); end
        step();
        checks++; if (bus.flush_full_req !== 1'b0) begin errors++; $display("FAIL flush_miss_single: got %0b expected 0", bus.flush_full_req); end
        // Failed restore: restore at N+1, flush at N+2.
        save_step(6'd7, 2'd2);
        resolve_step(6'd7, 1'b1);
        step();
        checks++; if ({bus.restore_checkpoint_valid, bus.mispredict_done, bus.flush_full_req} !== 3'b100) begin
            errors++; $display("FAIL flush_fail_restore: got %3b expected 100", {bus.restore_checkpoint_valid, bus.mispredict_done, bus.flush_full_req}); end
        step();
        checks++; if ({bus.flush_full_req, bus.rob_revert_start} !== 2'b10) begin errors++; $display("FAIL flush_fail_pulse: got %2b expected 10", {bus.flush_full_req, bus.rob_revert_start}); end
        step();
        checks++; if (dut.count_q !== 2'd0) begin errors++; $display("FAIL flush_fail_count: got %0d expected 0", dut.count_q); end
        // Correct prediction with no entry: nothing happens.
        resolve_step(6'd30, 1'b0);
        step();
        checks++; if ({bus.restore_checkpoint_valid, bus.flush_full_req, bus.resolve_ready} !== 3'b001) begin
            errors++; $display("FAIL flush_correct_miss: got %3b expected 001", {bus.restore_checkpoint_valid, bus.flush_full_req, bus.resolve_ready}); end
    endtask

    task automatic test_reset_mid();
        bus.restore_checkpoint_success = 1'b1;
        save_step(6'd4, 2'd3);
        resolve_step(6'd4, 1'b1);
        step();
        checks++; if (bus.restore_checkpoint_valid !== 1'b1) begin errors++; $display("FAIL rstmid_in_restore: got %0b expected 1", bus.restore_checkpoint_valid); end
        nRST = 1'b0;
        #1;
        bus.restore_checkpoint_success = 1'b0;
        checks++; if ({bus.restore_checkpoint_valid, bus.mispredict_done} !== 2'b00) begin errors++; $display("FAIL rstmid_outputs: got %2b expected 00", {bus.restore_checkpoint_valid, bus.mispredict_done}); end
        checks++; if ({bus.save_ready, bus.resolve_ready} !== 2'b11) begin errors++; $display("FAIL rstmid_ready: got %2b expected 11", {bus.save_ready, bus.resolve_ready}); end
        @(negedge CLK);
        nRST = 1'b1;
        save_step(6'd2, 2'd1);
        checks++; if ({bus.save_checkpoint_valid, bus.save_checkpoint_ROB_index} !== {1'b1, 6'd2}) begin errors++; $display("FAIL rstmid_save2: got %0b/%0d expected 1/2", bus.save_checkpoint_valid, bus.save_checkpoint_ROB_index); end
        step();
        checks++; if (dut.count_q !== 2'd1) begin errors++; $display("FAIL rstmid_count: got %0d expected 1", dut.count_q); end
        resolve_step(6'd2, 1'b0);
        step();
        checks++; if ({bus.restore_checkpoint_valid, bus.restore_checkpoint_safe_column} !== {1'b1, 2'd1}) begin
            errors++; $display("FAIL rstmid_res2: got %0b/%0d expected 1/1", bus.restore_checkpoint_valid, bus.restore_checkpoint_safe_column); end
    endtask
`endif

    initial begin
        test_reset();
        test_save_restore_correct();
        test_mispredict_success();
        test_fill();
        test_back_to_back();
`ifdef CKPT_REVERT_FALLBACK_EN
        test_revert_walk();
`else
        test_flush();
`endif
        test_reset_mid();
        repeat (2) @(negedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
